// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module  : led_pattern_engine
// Brief   : Steps one of four LED patterns on each synchronised step_in rise.
// Revision: 1.0 - initial release
// ============================================================================
module led_pattern_engine #(
    parameter int NUM_LEDS = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                step_in,
    input  logic [1:0]          mode,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_pulse,
    output logic [1:0]          mode_active
);

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] c_mode_chase_l = 2'b00;
    localparam logic [1:0] c_mode_chase_r = 2'b01;
    localparam logic [1:0] c_mode_bounce  = 2'b10;

    localparam logic [NUM_LEDS-1:0] c_lsb = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NUM_LEDS-1:0] c_msb = {1'b1, {(NUM_LEDS-1){1'b0}}};

    logic                s1_q, s2_q, s3_q;
    logic                pulse_q;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    dir_t                dir_q, dir_d;
    logic [1:0]          mode_q, mode_d;

    always_comb begin
        leds_d = leds_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (pulse_q && !pause) begin
            if (mode != mode_q) begin
                mode_d = mode;
                dir_d  = DIR_UP;
                case (mode)
                    c_mode_chase_l: leds_d = c_lsb;
                    c_mode_chase_r: leds_d = c_msb;
                    c_mode_bounce:  leds_d = c_lsb;
                    default:        leds_d = '0;
                endcase
            end else begin
                case (mode_q)
                    c_mode_chase_l: leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
                    c_mode_chase_r: leds_d = {leds_q[0], leds_q[NUM_LEDS-1:1]};
                    c_mode_bounce: begin
                        // End bits are tested before moving so an odd state still turns around cleanly.
                        if (dir_q == DIR_UP) begin
                            if (leds_q[NUM_LEDS-1]) begin
                                leds_d = leds_q >> 1;
                                dir_d  = DIR_DOWN;
                            end else begin
                                leds_d = leds_q << 1;
                                if (leds_q[NUM_LEDS-2]) dir_d = DIR_DOWN;
                            end
                        end else begin
                            if (leds_q[0]) begin
                                leds_d = leds_q << 1;
                                dir_d  = DIR_UP;
                            end else begin
                                leds_d = leds_q >> 1;
                                if (leds_q[1]) dir_d = DIR_UP;
                            end
                        end
                    end
                    default: begin
                        // DIR_UP is the fill phase, DIR_DOWN the drain phase.
                        if (dir_q == DIR_UP) begin
                            leds_d = {leds_q[NUM_LEDS-2:0], 1'b1};
                            if (&leds_q[NUM_LEDS-2:0]) dir_d = DIR_DOWN;
                        end else begin
                            leds_d = {leds_q[NUM_LEDS-2:0], 1'b0};
                            if (leds_q[NUM_LEDS-2:0] == '0) dir_d = DIR_UP;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
            leds_q  <= c_lsb;
            dir_q   <= DIR_UP;
            mode_q  <= c_mode_chase_l;
        end else begin
            s1_q    <= step_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= s2_q & ~s3_q;
            leds_q  <= leds_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign leds        = leds_q;
    assign step_pulse  = pulse_q;
    assign mode_active = mode_q;

endmodule
`default_nettype wire
